// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier core.
// The default operand width follows the display chain's NBITS.
package shift_add_multiplier_pkg;
    localparam int NBITS         = 8;
    localparam int DEFAULT_WIDTH = NBITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;
endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle of the multiplier: master drives operands and start,
// slave (the core) returns the product, sign/magnitude pair and status.
interface shift_add_multiplier_if
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int CW = $clog2(WIDTH + 1);

    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   magnitude;
    logic                 sign;
    logic [CW-1:0]        cycles;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product, magnitude, sign, cycles
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product, magnitude, sign, cycles
    );
endinterface

// File: rtl/shift_add_multiplier_abs_twos.sv
// Conditional two's-complement: passes the value through, or negates it when neg is set.
// Used both to take operand magnitudes and to re-apply the sign to the result.
module shift_add_multiplier_abs_twos #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? (~a + W'(1)) : a;
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: magnitudes are multiplied unsigned and
// the sign is re-applied on the way out, so the adder never sees negative values.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    shift_add_multiplier_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_pend_q, sign_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [PW-1:0]    product_q, product_d;
    logic [PW-1:0]    magnitude_q, magnitude_d;
    logic             sign_q, sign_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_neg, b_neg, res_neg;
    logic [PW-1:0]    res_val;

    assign a_neg   = bus.signed_mode & bus.multiplicand[WIDTH-1];
    assign b_neg   = bus.signed_mode & bus.multiplier[WIDTH-1];
    // A zero product is never reported negative, even for e.g. -5 x 0.
    assign res_neg = sign_pend_q & (|acc_q);

    shift_add_multiplier_abs_twos #(.W(WIDTH)) u_abs_a (
        .a(bus.multiplicand), .neg(a_neg), .y(a_mag)
    );
    shift_add_multiplier_abs_twos #(.W(WIDTH)) u_abs_b (
        .a(bus.multiplier), .neg(b_neg), .y(b_mag)
    );
    shift_add_multiplier_abs_twos #(.W(PW)) u_abs_res (
        .a(acc_q), .neg(res_neg), .y(res_val)
    );

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sign_pend_d = sign_pend_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        product_d   = product_q;
        magnitude_d = magnitude_q;
        sign_d      = sign_q;
        cycles_d    = cycles_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d     = ST_RUN;
                    busy_d      = 1'b1;
                    mcand_d     = {{WIDTH{1'b0}}, a_mag};
                    mplier_d    = b_mag;
                    sign_pend_d = a_neg ^ b_neg;
                    acc_d       = '0;
                    cnt_d       = '0;
                end
            end
            ST_RUN: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // At least one iteration always runs, even for a zero multiplier.
                if (cnt_d == CW'(WIDTH) || (EARLY_TERM && mplier_d == '0))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                magnitude_d = acc_q;
                sign_d      = res_neg;
                product_d   = res_val;
                cycles_d    = cnt_q;
                done_d      = 1'b1;
                busy_d      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            product_q   <= '0;
            magnitude_q <= '0;
            sign_q      <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sign_pend_q <= sign_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            product_q   <= product_d;
            magnitude_q <= magnitude_d;
            sign_q      <= sign_d;
            cycles_q    <= cycles_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.product   = product_q;
    assign bus.magnitude = magnitude_q;
    assign bus.sign      = sign_q;
    assign bus.cycles    = cycles_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: one early-terminating and one full-length core,
// checked against an integer-arithmetic reference.
module tb_shift_add_multiplier;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_add_multiplier_if #(.WIDTH(W)) if_et ();
    shift_add_multiplier_if #(.WIDTH(W)) if_ne ();

    shift_add_multiplier #(.WIDTH(W), .EARLY_TERM(1'b1)) dut_et (
        .clk(clk), .rst(rst), .bus(if_et)
    );
    shift_add_multiplier #(.WIDTH(W), .EARLY_TERM(1'b0)) dut_ne (
        .clk(clk), .rst(rst), .bus(if_ne)
    );

    int total = 0;
    int bad   = 0;
    bit sel   = 1'b1;

    logic        o_done, o_busy, o_sign;
    logic [15:0] o_prod, o_mag;
    logic [3:0]  o_cyc;

    always_comb begin
        if (sel) begin
            o_done = if_et.done; o_busy = if_et.busy; o_sign = if_et.sign;
            o_prod = if_et.product; o_mag = if_et.magnitude; o_cyc = if_et.cycles;
        end else begin
            o_done = if_ne.done; o_busy = if_ne.busy; o_sign = if_ne.sign;
            o_prod = if_ne.product; o_mag = if_ne.magnitude; o_cyc = if_ne.cycles;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit s, input bit st, input bit sm, input logic [7:0] a, input logic [7:0] b);
        if (s) begin
            if_et.start = st; if_et.signed_mode = sm; if_et.multiplicand = a; if_et.multiplier = b;
        end else begin
            if_ne.start = st; if_ne.signed_mode = sm; if_ne.multiplicand = a; if_ne.multiplier = b;
        end
    endtask

    // Reference: plain integer product, sign/magnitude from it, iterations from |B|.
    task automatic model(input bit et, input bit sm, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] e_prod, output logic [15:0] e_mag,
                         output logic e_sign, output int e_n);
        int ia, ib, p, ap, mb;
        ia = sm ? int'($signed(a)) : int'(a);
        ib = sm ? int'($signed(b)) : int'(b);
        p  = ia * ib;
        ap = (p < 0) ? -p : p;
        mb = (ib < 0) ? -ib : ib;
        e_prod = p[15:0];
        e_mag  = ap[15:0];
        e_sign = (p < 0);
        e_n    = !et ? W : (mb == 0 ? 1 : $clog2(mb + 1));
    endtask

    // Starts an operation at a negedge and returns at the negedge where done is seen.
    task automatic run_op(input bit s, input bit sm, input logic [7:0] a, input logic [7:0] b,
                          input string tag);
        logic [15:0] e_prod, e_mag;
        logic        e_sign;
        int          e_n, k;
        model(s, sm, a, b, e_prod, e_mag, e_sign, e_n);
        sel = s;
        drive(s, 1'b1, sm, a, b);
        @(negedge clk);
        drive(s, 1'b0, ~sm, ~a, ~b);
        k = 1;
        chk({tag, ".busy"}, 32'(o_busy), 32'd1);
        while (!o_done && k < 2 * W + 8) begin
            @(negedge clk);
            k++;
        end
        if (!o_done) begin
            chk({tag, ".timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, ".lat"},  32'(k - 1), 32'(e_n + 1));
            chk({tag, ".prod"}, 32'(o_prod), 32'(e_prod));
            chk({tag, ".mag"},  32'(o_mag),  32'(e_mag));
            chk({tag, ".sign"}, 32'(o_sign), 32'(e_sign));
            chk({tag, ".cyc"},  32'(o_cyc),  32'(e_n));
        end
    endtask

    task automatic post_idle(input string tag);
        @(negedge clk);
        chk({tag, ".done_clr"}, 32'(o_done), 32'd0);
        chk({tag, ".busy_clr"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        logic [15:0] got_p;
        logic [3:0]  got_c;
        int          pulses;
        bit          rs, rsm;
        logic [7:0]  ra, rb;

        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #1;
            chk("rst.done", 32'(o_done), 32'd0);
            chk("rst.busy", 32'(o_busy), 32'd0);
            chk("rst.prod", 32'(o_prod), 32'd0);
            chk("rst.mag",  32'(o_mag),  32'd0);
            chk("rst.sign", 32'(o_sign), 32'd0);
            chk("rst.cyc",  32'(o_cyc),  32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b1, 1'b0, 8'd13, 8'd11, "u13x11");
        post_idle("u13x11");
        run_op(1'b1, 1'b1, 8'hFD, 8'hFE, "s-3x-2");
        run_op(1'b1, 1'b1, 8'd7, 8'd5, "s7x5_b2b");
        post_idle("s7x5_b2b");
        run_op(1'b1, 1'b1, 8'hFF, 8'h02, "s-1x2");
        post_idle("s-1x2");
        run_op(1'b1, 1'b1, 8'h80, 8'h80, "s-128sq");
        post_idle("s-128sq");
        run_op(1'b1, 1'b1, 8'hFB, 8'h00, "s-5x0");
        post_idle("s-5x0");
        run_op(1'b0, 1'b0, 8'hFF, 8'hFF, "u255sq_ne");
        post_idle("u255sq_ne");

        // start pulses while RUN and while in the result-register cycle must be ignored
        sel = 1'b1;
        pulses = 0; got_p = '0; got_c = '0;
        drive(1'b1, 1'b1, 1'b0, 8'd200, 8'd201);
        for (int k = 1; k <= W + 6; k++) begin
            @(negedge clk);
            if (o_done) begin pulses++; got_p = o_prod; got_c = o_cyc; end
            if (k == 1)     drive(1'b1, 1'b0, 1'b0, 8'd200, 8'd201);
            if (k == 3)     drive(1'b1, 1'b1, 1'b1, 8'd5, 8'd5);
            if (k == 4)     drive(1'b1, 1'b0, 1'b0, 8'd200, 8'd201);
            if (k == W + 1) drive(1'b1, 1'b1, 1'b1, 8'hF0, 8'h03);
            if (k == W + 2) drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        end
        chk("ign.pulses", 32'(pulses), 32'd1);
        chk("ign.prod",   32'(got_p),  32'd40200);
        chk("ign.cyc",    32'(got_c),  32'd8);
        chk("ign.busy",   32'(o_busy), 32'd0);

        // reset mid-operation
        pulses = 0;
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (o_done) pulses++;
            if (k == 1) drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                chk("mrst.busy", 32'(o_busy), 32'd0);
                chk("mrst.done", 32'(o_done), 32'd0);
                chk("mrst.prod", 32'(o_prod), 32'd0);
                chk("mrst.mag",  32'(o_mag),  32'd0);
                chk("mrst.sign", 32'(o_sign), 32'd0);
                chk("mrst.cyc",  32'(o_cyc),  32'd0);
                rst = 1'b0;
            end
        end
        chk("mrst.nodone", 32'(pulses), 32'd0);
        run_op(1'b1, 1'b0, 8'd3, 8'd3, "u3x3");
        post_idle("u3x3");

        for (int i = 0; i < 60; i++) begin
            rs  = bit'(i & 1);
            rsm = bit'($urandom_range(0, 1));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 8'h00;
                1: ra = 8'h80;
                2: rb = 8'h80;
                default: ;
            endcase
            run_op(rs, rsm, ra, rb, "rand");
            if ($urandom_range(0, 1) == 1) post_idle("rand");
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Parametrised sequential shift-and-add multiplier with a start/done handshake, run-time signed/unsigned mode and optional early termination. Generalises the fixed-width signed multiplier datapath (control FSM, counter, shifter, adder, sign and two's-complement stages) into one self-contained core. Sits between the operand inputs and the BCD/7-segment display path. Provides both the two's-complement product and a sign/magnitude pair for the display chain.

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits.
- EARLY_TERM, 1, when 1 stop iterating once the remaining multiplier bits are all zero.

- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- signed_mode  in  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
- multiplicand  in  WIDTH  operand A; sampled with start.
- multiplier  in  WIDTH  operand B, drives iteration count; sampled with start.
- busy  out  1  high from the accepting edge until the DONE cycle ends.
- done  out  1  one-cycle pulse; product outputs valid from this cycle.
- product  out  2*WIDTH  two's-complement result, held until the next done.
- magnitude  out  2*WIDTH  |product|.
- sign  out  1  1 when the product is negative; 0 for zero product.
- cycles  out  $clog2(WIDTH+1)  iterations used by the last operation.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on start=1, capture operands and go to RUN. In signed_mode, load the magnitudes of both operands: for negative values, the two's complement zero-extended to WIDTH bits. In unsigned mode, load the raw values. Record sign_pending = msbA ^ msbB in signed mode, else 0. Clear the accumulator (2*WIDTH bits) and the iteration counter.
- RUN, per cycle:
  - If mplier_reg[0]=1, add mcand_reg (2*WIDTH bits) to the accumulator.
  - Shift mcand_reg left by 1 and mplier_reg right by 1; increment the counter.
  - Exit to DONE when counter reaches WIDTH, or when EARLY_TERM=1 and the shifted mplier_reg is zero.
  - Minimum one iteration, including for a zero multiplier.
- DONE, on entry:
  - magnitude ← accumulator.
  - sign ← sign_pending AND (accumulator≠0).
  - product ← sign ? −accumulator : accumulator.
  - cycles ← counter.
  - done=1 for exactly one cycle, then return to IDLE.
- Magnitude of −2^(WIDTH−1) is 2^(WIDTH−1). It fits the WIDTH-bit unsigned register, and the worst case (−2^(WIDTH−1))² fits in 2*WIDTH bits.
- Accumulator additions never overflow 2*WIDTH bits; no carry-out is kept.
- start while busy (RUN or DONE) is ignored; the operation in flight is unaffected.
- Operand and mode changes after the accepting edge are ignored.
- rst has priority over start in the same cycle.
- rst mid-operation: FSM goes to IDLE; busy, done, product, magnitude, sign, cycles and all internal registers go to 0. No done pulse is emitted.

## Timing
- Reset values: busy=0, done=0, product=0, magnitude=0, sign=0, cycles=0, state IDLE.
- Edge 0 samples start=1; busy=1 from edge 0.
- Edges 1..N perform the N iterations (1 ≤ N ≤ WIDTH).
- Edge N+1 registers the results and sets done=1.
- Edge N+2 clears done and busy; state is IDLE.
- Latency from the start-sampling edge to done: N+1 cycles. Worst case WIDTH+1; with EARLY_TERM=0, always WIDTH+1.
- Earliest next accepted start: sampled at edge N+2 (back-to-back operations spaced N+2 cycles).
- Outputs hold between done pulses; they are not cleared by a new start.

## Structure
- Shared package Parameter_Definitions:
  - mult_state_t enum {IDLE, RUN, DONE}.
  - Default WIDTH constant, tied to the existing NBits.
- One sub-module, abs_twos: combinational conditional two's-complement/magnitude.
  - Parametrised width.
  - Instanced twice at WIDTH for operand magnitudes and once at 2*WIDTH for the result negation.
- FSM, counter, shift registers and accumulator live in the top module.

## Test plan
- Unsigned, WIDTH=8, EARLY_TERM=1, 13×11 → product=143, magnitude=143, sign=0, cycles=4, done 5 cycles after start.
- Signed −3×−2 → product=6, sign=0, cycles=2; then signed 7×5 back-to-back at the earliest accepted start → product=35, cycles=3.
- Signed −1×2 → product=0xFFFE, magnitude=2, sign=1, cycles=2; signed −128×−128 → product=0x4000, sign=0, cycles=8.
- Zero multiplier: signed −5×0 → product=0, sign=0, cycles=1. Unsigned 255×255 with EARLY_TERM=0 → product=65025, cycles=8, done exactly 9 cycles after start.
- start pulses during RUN and during the DONE cycle, with changed operands → ignored; result matches the first operands; exactly one done pulse.
- rst asserted at iteration 3 of 255×255 → all outputs 0 next cycle, no done pulse. A following start for 3×3 → product=9, cycles=2.
